multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RISC-V core.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the aluOp code consumed by ALUControl, plus all datapath mux selects and write enables.
- Handshakes with a variable-latency unified memory and flags illegal opcodes and memory timeouts.

Parameters:
STALL_LIMIT, 16, max consecutive cycles waiting on memReady before memError is raised (>=2)
CNT_W, $clog2(STALL_LIMIT+1), width of the stall counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  instruction[6:0] from the instruction register
memReady  input  1  memory completes the current read/write this cycle
zero  input  1  ALU zero flag (used only in BRANCH)
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load qualified by zero (this block performs the AND internally; see Behaviour)
iOrD  output  1  memory address select: 0 = PC, 1 = ALUOut
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  load IR and oldPC
regWrite  output  1  register file write enable
memToReg  output  1  writeback select: 0 = ALUOut, 1 = MDR
aluSrcA  output  1  0 = oldPC/PC, 1 = register A
aluSrcB  output  2  00 = register B, 01 = constant 4, 10 = immediate
aluOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded
pcSource  output  1  0 = ALU result, 1 = ALUOut
illegalInstr  output  1  one-cycle pulse on an unknown opcode
memError  output  1  sticky flag set on memory timeout; cleared only by reset
state  output  4  current state encoding (debug)

Behaviour:
- Reset (async): state = FETCH, stall counter = 0, memError = 0, every other output 0.
- Outputs are Moore, decoded from state only, except the handshake-qualified strobes, which are also gated by memReady.
- FETCH: memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=0.
  - Hold while memReady=0.
  - On memReady=1: irWrite=1 and pcWrite=1 in that same cycle, then go to DECODE.
- DECODE: aluSrcA=0 (oldPC), aluSrcB=10, aluOp=00 to precompute the branch target into ALUOut. Next state by opcode:
  - 0000011 -> MEM_ADDR
  - 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - other -> FETCH, with illegalInstr=1 for one cycle
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Next is MEM_READ for a load, MEM_WRITE for a store (opcode is held stable by the IR).
- MEM_READ: memRead=1, iOrD=1. Hold until memReady=1, then go to MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, then go to FETCH.
- MEM_WRITE: memWrite=1, iOrD=1. Hold until memReady=1, then go to FETCH.
- EXEC_R: aluSrcA=1, aluSrcB=00, aluOp=10, then go to ALU_WB.
- EXEC_I: aluSrcA=1, aluSrcB=10, aluOp=10, then go to ALU_WB.
- ALU_WB: regWrite=1, memToReg=0, then go to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=1, pcWriteCond=1, then go to FETCH.
  - Because pcWriteCond is ANDed with zero internally, it is high only when zero=1; the datapath uses it directly as a PC enable.
- Stall counter:
  - Counts cycles in a wait state (FETCH, MEM_READ, MEM_WRITE) with memReady=0.
  - Clears on memReady=1 and on any state change.
  - Saturates at STALL_LIMIT.
  - When the counter reaches STALL_LIMIT: memError is set, the request is abandoned, and the FSM returns to FETCH with the counter cleared. From FETCH a fresh fetch is retried; the PC is unchanged.
- memReady while not in a wait state is ignored.
- Reset asserted mid-access drops memRead/memWrite asynchronously.
- Unused state encodings go to FETCH.
- The 4-bit state encoding lives in the package, so the bench can check `state`.

Decomposition:
- Package ctrl_pkg:
  - state_t enum (FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH)
  - opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH)
  - aluOp localparams (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - aluSrcB localparams
- One sub-module, mem_stall_timer: the saturating stall counter plus the sticky memError flag.

Test Plan:
- R-type: opcode=0110011, memReady=1 always -> states FETCH, DECODE, EXEC_R, ALU_WB, FETCH. aluOp=10 in EXEC_R; regWrite=1 only in ALU_WB. Instruction takes 4 cycles.
- Load with memReady low 3 cycles in MEM_READ: opcode=0000011 -> MEM_READ lasts 4 cycles, MEM_WB follows with memToReg=1, memError stays 0.
- Store: opcode=0100011 -> memWrite=1 and iOrD=1 only in MEM_WRITE, regWrite never set. Branch with zero=1 -> pcWriteCond=1 and aluOp=01 in BRANCH; repeat with zero=0 -> pcWriteCond=0.
- Illegal opcode 1111111 -> DECODE goes to FETCH, illegalInstr high exactly 1 cycle, no regWrite/memWrite.
- Timeout: memReady held 0 in FETCH for STALL_LIMIT (16) cycles -> memError set, FSM re-enters FETCH, memError stays 1 after later memReady=1 until reset.
- Async reset asserted in MEM_WRITE mid-stall -> memWrite falls before the next clk edge, state=FETCH, memError=0 after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes and ALU/mux select codes.
// The 4-bit state encoding is exported on the debug port, so it is fixed here.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mem_stall_timer.sv
// Saturating count of consecutive memReady-low cycles in a wait state, plus sticky memError.
// timeout is combinational on the STALL_LIMIT-th stalled cycle; memError follows one edge later.
module mem_stall_timer #(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = $clog2(STALL_LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    input  logic state_change,
    output logic timeout,
    output logic mem_error
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(STALL_LIMIT);

    logic [CNT_W-1:0] stall_count;
    logic             stalled;

    assign stalled = waiting && !mem_ready;
    assign timeout = stalled && (stall_count >= LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (timeout || !stalled || state_change) begin
            stall_count <= '0;
        end else if (stall_count != SAT) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Only reset clears the error; a later successful access leaves it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_error <= 1'b0;
        end else if (timeout) begin
            mem_error <= 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: Moore decode of datapath controls, irWrite/pcWrite gated by memReady.
// Waits in FETCH/MEM_READ/MEM_WRITE for memReady; STALL_LIMIT stalled cycles abandon the access.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = $clog2(STALL_LIMIT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       memReady,
    input  logic       zero,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iOrD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       pcSource,
    output logic       illegalInstr,
    output logic       memError,
    output logic [3:0] state
);

    state_t cur_state;
    state_t nxt_state;
    logic   timeout;
    logic   state_change;

    assign state        = cur_state;
    assign state_change = (nxt_state != cur_state);

    mem_stall_timer #(
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) u_stall (
        .clk          (clk),
        .reset        (reset),
        .waiting      (is_wait_state(cur_state)),
        .mem_ready    (memReady),
        .state_change (state_change),
        .timeout      (timeout),
        .mem_error    (memError)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            FETCH: begin
                if (timeout)       nxt_state = FETCH;
                else if (memReady) nxt_state = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt_state = MEM_ADDR;
                    OP_RTYPE:          nxt_state = EXEC_R;
                    OP_ITYPE:          nxt_state = EXEC_I;
                    OP_BRANCH:         nxt_state = BRANCH;
                    default:           nxt_state = FETCH;
                endcase
            end
            MEM_ADDR: begin
                if (opcode == OP_LOAD)       nxt_state = MEM_READ;
                else if (opcode == OP_STORE) nxt_state = MEM_WRITE;
                else                         nxt_state = FETCH;
            end
            MEM_READ: begin
                if (timeout)       nxt_state = FETCH;
                else if (memReady) nxt_state = MEM_WB;
            end
            MEM_WRITE: begin
                if (timeout || memReady) nxt_state = FETCH;
            end
            MEM_WB:  nxt_state = FETCH;
            EXEC_R:  nxt_state = ALU_WB;
            EXEC_I:  nxt_state = ALU_WB;
            ALU_WB:  nxt_state = FETCH;
            BRANCH:  nxt_state = FETCH;
            default: nxt_state = FETCH;
        endcase
    end

    // Reset forces every control low combinationally so an in-flight request drops immediately.
    always_comb begin
        pcWrite      = 1'b0;
        pcWriteCond  = 1'b0;
        iOrD         = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        irWrite      = 1'b0;
        regWrite     = 1'b0;
        memToReg     = 1'b0;
        aluSrcA      = 1'b0;
        aluSrcB      = SRCB_REG;
        aluOp        = ALUOP_ADD;
        pcSource     = 1'b0;
        illegalInstr = 1'b0;
        if (!reset) begin
            case (cur_state)
                FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = SRCB_FOUR;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                DECODE: begin
                    aluSrcB      = SRCB_IMM;
                    illegalInstr = !is_legal_op(opcode);
                end
                MEM_ADDR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                MEM_READ: begin
                    memRead = 1'b1;
                    iOrD    = 1'b1;
                end
                MEM_WB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                end
                MEM_WRITE: begin
                    memWrite = 1'b1;
                    iOrD     = 1'b1;
                end
                EXEC_R: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_REG;
                    aluOp   = ALUOP_FUNCT;
                end
                EXEC_I: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                    aluOp   = ALUOP_FUNCT;
                end
                ALU_WB: begin
                    regWrite = 1'b1;
                end
                BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluSrcB     = SRCB_REG;
                    aluOp       = ALUOP_SUB;
                    pcSource    = 1'b1;
                    pcWriteCond = zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Drives instruction streams with random stalls and compares every cycle to a trace model.
module tb_multicycle_control;
    import ctrl_pkg::*;

    localparam int LIMIT = 16;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       memReady;
    logic       zero;
    logic       pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite;
    logic       regWrite, memToReg, aluSrcA, pcSource, illegalInstr, memError;
    logic [1:0] aluSrcB, aluOp;
    logic [3:0] state;
    logic [19:0] outv;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic        z;
        logic [19:0] exp;
    } cyc_t;

    cyc_t       q[$];
    logic [6:0] m_op;
    logic       m_merr;

    multicycle_control #(.STALL_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady), .zero(zero),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iOrD(iOrD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite), .memToReg(memToReg),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
        .illegalInstr(illegalInstr), .memError(memError), .state(state)
    );

    // Bit layout: state[19:16] memRead memWrite iOrD irWrite pcWrite pcWriteCond regWrite
    // memToReg aluSrcA aluSrcB[6:5] aluOp[4:3] pcSource illegalInstr memError.
    assign outv = {state, memRead, memWrite, iOrD, irWrite, pcWrite, pcWriteCond, regWrite,
                   memToReg, aluSrcA, aluSrcB, aluOp, pcSource, illegalInstr, memError};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] exp_of(input state_t st, input logic rdy, input logic z,
                                           input logic [6:0] op, input logic merr);
        logic mr = 0, mw = 0, iod = 0, irw = 0, pcw = 0, pcc = 0, rw = 0, m2r = 0;
        logic asa = 0, pcs = 0, ill = 0;
        logic [1:0] asb = 2'b00, aop = 2'b00;
        logic legal;
        legal = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
                (op == 7'b0010011) || (op == 7'b1100011);
        case (st)
            FETCH:     begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            DECODE:    begin asb = 2'b10; ill = !legal; end
            MEM_ADDR:  begin asa = 1; asb = 2'b10; end
            MEM_READ:  begin mr = 1; iod = 1; end
            MEM_WB:    begin rw = 1; m2r = 1; end
            MEM_WRITE: begin mw = 1; iod = 1; end
            EXEC_R:    begin asa = 1; asb = 2'b00; aop = 2'b10; end
            EXEC_I:    begin asa = 1; asb = 2'b10; aop = 2'b10; end
            ALU_WB:    begin rw = 1; end
            BRANCH:    begin asa = 1; aop = 2'b01; pcs = 1; pcc = z; end
            default:   ;
        endcase
        return {4'(st), mr, mw, iod, irw, pcw, pcc, rw, m2r, asa, asb, aop, pcs, ill, merr};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input state_t st, input logic rdy, input logic z);
        cyc_t c;
        c.op  = m_op;
        c.rdy = rdy;
        c.z   = z;
        c.exp = exp_of(st, rdy, z, m_op, m_merr);
        q.push_back(c);
    endtask

    // Expected trace of one instruction; a wait of LIMIT stalled cycles abandons and sets the error.
    task automatic gen_instr(input logic [6:0] op, input int fstall, input int mstall, input logic zb);
        int n;
        state_t wst;
        m_op = op;
        n = fstall;
        while (n >= LIMIT) begin
            repeat (LIMIT) push(FETCH, 1'b0, rb());
            m_merr = 1'b1;
            n -= LIMIT;
        end
        repeat (n) push(FETCH, 1'b0, rb());
        push(FETCH, 1'b1, rb());
        push(DECODE, rb(), rb());
        case (op)
            7'b0000011, 7'b0100011: begin
                push(MEM_ADDR, rb(), rb());
                wst = (op == 7'b0000011) ? MEM_READ : MEM_WRITE;
                if (mstall >= LIMIT) begin
                    repeat (LIMIT) push(wst, 1'b0, rb());
                    m_merr = 1'b1;
                    return;
                end
                repeat (mstall) push(wst, 1'b0, rb());
                push(wst, 1'b1, rb());
                if (op == 7'b0000011) push(MEM_WB, rb(), rb());
            end
            7'b0110011: begin push(EXEC_R, rb(), rb()); push(ALU_WB, rb(), rb()); end
            7'b0010011: begin push(EXEC_I, rb(), rb()); push(ALU_WB, rb(), rb()); end
            7'b1100011: push(BRANCH, rb(), zb);
            default: ;
        endcase
    endtask

    // Called at a falling edge; drives one cycle's inputs, samples, then waits for the next falling edge.
    task automatic step(input logic [6:0] op, input logic rdy, input logic z, output logic [19:0] obs);
        opcode   = op;
        memReady = rdy;
        zero     = z;
        #1;
        obs = outv;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        memReady = 1'b1;
        #1;
        n_cmp++;
        if (outv !== 20'h00000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %05h want %05h", outv, 20'h00000);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (outv !== 20'h00000) begin
            n_fail++;
            $display("FAIL reset_hold: got %05h want %05h", outv, 20'h00000);
        end
        @(negedge clk);
        reset    = 1'b0;
        m_merr   = 1'b0;
    endtask

    task automatic test_rtype();
        logic [19:0] obs;
        int rw_cnt = 0;
        gen_instr(7'b0110011, 0, 0, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].op, q[i].rdy, q[i].z, obs);
            rw_cnt += int'(obs[9]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_fail++;
                $display("FAIL rtype cycle %0d: got %05h want %05h", i, obs, q[i].exp);
            end
        end
        n_cmp++;
        if (rw_cnt != 1) begin
            n_fail++;
            $display("FAIL rtype_regwrite_count: got %0d want 1", rw_cnt);
        end
        q.delete();
    endtask

    task automatic test_load_stall();
        logic [19:0] obs;
        int rd_cycles = 0;
        gen_instr(7'b0000011, 2, 3, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].op, q[i].rdy, q[i].z, obs);
            if (obs[19:16] == 4'(MEM_READ)) rd_cycles++;
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_fail++;
                $display("FAIL load cycle %0d: got %05h want %05h", i, obs, q[i].exp);
            end
        end
        n_cmp++;
        if (rd_cycles != 4) begin
            n_fail++;
            $display("FAIL load_memread_cycles: got %0d want 4", rd_cycles);
        end
        q.delete();
    endtask

    task automatic test_store_branch();
        logic [19:0] obs;
        int rw_cnt = 0, mw_cnt = 0, pcc_cnt = 0;
        gen_instr(7'b0100011, 0, 2, 1'b0);
        gen_instr(7'b1100011, 0, 0, 1'b1);
        gen_instr(7'b1100011, 1, 0, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].op, q[i].rdy, q[i].z, obs);
            rw_cnt  += int'(obs[9]);
            mw_cnt  += int'(obs[14]);
            pcc_cnt += int'(obs[10]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_fail++;
                $display("FAIL store_branch cycle %0d: got %05h want %05h", i, obs, q[i].exp);
            end
        end
        n_cmp++;
        if (rw_cnt != 0 || mw_cnt != 3 || pcc_cnt != 1) begin
            n_fail++;
            $display("FAIL store_branch_counts: regWrite %0d memWrite %0d pcWriteCond %0d want 0 3 1",
                     rw_cnt, mw_cnt, pcc_cnt);
        end
        q.delete();
    endtask

    task automatic test_illegal();
        logic [19:0] obs;
        int ill_cnt = 0, wr_cnt = 0;
        gen_instr(7'b1111111, 0, 0, 1'b0);
        gen_instr(7'b0110011, 0, 0, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].op, q[i].rdy, q[i].z, obs);
            ill_cnt += int'(obs[1]);
            if (i < 2) wr_cnt += int'(obs[9] | obs[14]);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_fail++;
                $display("FAIL illegal cycle %0d: got %05h want %05h", i, obs, q[i].exp);
            end
        end
        n_cmp++;
        if (ill_cnt != 1 || wr_cnt != 0) begin
            n_fail++;
            $display("FAIL illegal_pulse: illegalInstr %0d writes %0d want 1 0", ill_cnt, wr_cnt);
        end
        q.delete();
    endtask

    task automatic test_timeout();
        logic [19:0] obs;
        gen_instr(7'b0110011, LIMIT - 1, 0, 1'b0);
        gen_instr(7'b0110011, LIMIT, 0, 1'b0);
        gen_instr(7'b0000011, 0, LIMIT, 1'b0);
        gen_instr(7'b0010011, 0, 0, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].op, q[i].rdy, q[i].z, obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: got %05h want %05h", i, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_async_reset();
        logic [19:0] obs;
        gen_instr(7'b0100011, 0, 10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(q[i].op, q[i].rdy, q[i].z, obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_fail++;
                $display("FAIL areset_lead cycle %0d: got %05h want %05h", i, obs, q[i].exp);
            end
        end
        q.delete();
        memReady = 1'b0;
        #1;
        n_cmp++;
        if (memWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_prewrite: memWrite got %b want 1", memWrite);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (outv !== 20'h00000) begin
            n_fail++;
            $display("FAIL areset_drop: got %05h want %05h", outv, 20'h00000);
        end
        @(negedge clk);
        reset  = 1'b0;
        m_merr = 1'b0;
        gen_instr(7'b0010011, 1, 0, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].op, q[i].rdy, q[i].z, obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_fail++;
                $display("FAIL areset_after cycle %0d: got %05h want %05h", i, obs, q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_random();
        logic [19:0] obs;
        logic [6:0] legal_ops [5];
        logic [6:0] op;
        int mst;
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
        for (int n = 0; n < 40; n++) begin
            op  = ($urandom_range(0, 5) == 5) ? 7'($urandom) : legal_ops[$urandom_range(0, 4)];
            mst = ($urandom_range(0, 9) == 0) ? LIMIT : int'($urandom_range(0, 4));
            gen_instr(op, $urandom_range(0, 4), mst, rb());
            for (int i = 0; i < q.size(); i++) begin
                step(q[i].op, q[i].rdy, q[i].z, obs);
                n_cmp++;
                if (obs !== q[i].exp) begin
                    n_fail++;
                    $display("FAIL random instr %0d op %b cycle %0d: got %05h want %05h",
                             n, op, i, obs, q[i].exp);
                end
            end
            q.delete();
        end
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 7'd0;
        memReady = 1'b0;
        zero     = 1'b0;
        m_op     = 7'd0;
        m_merr   = 1'b0;
        test_reset();
        test_rtype();
        test_load_stall();
        test_store_branch();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
